// File: rtl/aximm_burst_leader.sv
// AXI4 burst leader: accepts one command at a time, issues one INCR write or read burst with a seeded
// data pattern, and checks the response. Define AXIMM_LEADER_RDCHK_EN to also compare read data.
module aximm_burst_leader #(
  parameter int DWIDTH    = 128,
  parameter int ADDRWIDTH = 32,
  parameter int IDWIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  // command
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_wr,
  input  logic [ADDRWIDTH-1:0]   cmd_addr,
  input  logic [7:0]             cmd_len,
  input  logic [IDWIDTH-1:0]     cmd_id,
  input  logic [31:0]            cmd_seed,
  // status
  output logic                   busy,
  output logic                   done,
  output logic                   done_err,
  output logic [15:0]            err_cnt,
  // AW
  output logic [IDWIDTH-1:0]     user_awid,
  output logic [ADDRWIDTH-1:0]   user_awaddr,
  output logic [7:0]             user_awlen,
  output logic [2:0]             user_awsize,
  output logic [1:0]             user_awburst,
  output logic                   user_awvalid,
  input  logic                   user_awready,
  // W
  output logic [IDWIDTH-1:0]     user_wid,
  output logic [DWIDTH-1:0]      user_wdata,
  output logic [DWIDTH/8-1:0]    user_wstrb,
  output logic                   user_wlast,
  output logic                   user_wvalid,
  input  logic                   user_wready,
  // B
  input  logic [IDWIDTH-1:0]     user_bid,
  input  logic [1:0]             user_bresp,
  input  logic                   user_bvalid,
  output logic                   user_bready,
  // AR
  output logic [IDWIDTH-1:0]     user_arid,
  output logic [ADDRWIDTH-1:0]   user_araddr,
  output logic [7:0]             user_arlen,
  output logic [2:0]             user_arsize,
  output logic [1:0]             user_arburst,
  output logic                   user_arvalid,
  input  logic                   user_arready,
  // R
  input  logic [IDWIDTH-1:0]     user_rid,
  input  logic [DWIDTH-1:0]      user_rdata,
  input  logic [1:0]             user_rresp,
  input  logic                   user_rlast,
  input  logic                   user_rvalid,
  output logic                   user_rready
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
  } state_t;

  localparam logic [2:0] LP_SIZE = 3'($clog2(DWIDTH / 8));

  state_t                 r_state;
  state_t                 w_next;
  logic [ADDRWIDTH-1:0]   r_addr;
  logic [7:0]             r_len;
  logic [IDWIDTH-1:0]     r_id;
  logic [31:0]            r_seed;
  logic [7:0]             r_k;
  logic                   r_err;
  logic                   r_past;
  logic [15:0]            r_err_cnt;

  logic                   w_cmd_hs;
  logic                   w_aw_hs;
  logic                   w_w_hs;
  logic                   w_b_hs;
  logic                   w_ar_hs;
  logic                   w_r_hs;
  logic                   w_last_beat;
  logic [DWIDTH-1:0]      w_pattern;
  logic                   w_rd_mismatch;
  logic                   w_rd_beat_err;

  assign w_cmd_hs    = cmd_valid & cmd_ready;
  assign w_aw_hs     = user_awvalid & user_awready;
  assign w_w_hs      = user_wvalid & user_wready;
  assign w_b_hs      = user_bvalid & user_bready;
  assign w_ar_hs     = user_arvalid & user_arready;
  assign w_r_hs      = user_rvalid & user_rready;
  assign w_last_beat = (r_k == r_len);
  assign w_pattern   = {(DWIDTH/32){r_seed + {24'd0, r_k}}};

`ifdef AXIMM_LEADER_RDCHK_EN
  assign w_rd_mismatch = (user_rdata != w_pattern);
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^user_rdata;
  assign w_rd_mismatch  = 1'b0;
`endif

  // r_past marks that the beat at k == len went by without rlast: every later beat is an overrun.
  assign w_rd_beat_err = (user_rresp != 2'b00) | (user_rid != r_id) | w_rd_mismatch | r_past
                       | (user_rlast & ~w_last_beat);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: each combinational block assigns defaults first so no path leaves a signal unassigned (no latches).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_cmd_hs) w_next = cmd_wr ? S_WR_ADDR : S_RD_ADDR;
      S_WR_ADDR: if (w_aw_hs) w_next = S_WR_DATA;
      S_WR_DATA: if (w_w_hs && w_last_beat) w_next = S_WR_RESP;
      S_WR_RESP: if (w_b_hs) w_next = S_DONE;
      S_RD_ADDR: if (w_ar_hs) w_next = S_RD_DATA;
      S_RD_DATA: if (w_r_hs && user_rlast) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    // cmd_ready stays low while reset is held, even though the state is already IDLE.
    cmd_ready    = (r_state == S_IDLE) & ~rst;
    busy         = (r_state != S_IDLE);
    done         = (r_state == S_DONE);
    done_err     = (r_state == S_DONE) & r_err;
    user_awvalid = (r_state == S_WR_ADDR);
    user_wvalid  = (r_state == S_WR_DATA);
    user_bready  = (r_state == S_WR_RESP);
    user_arvalid = (r_state == S_RD_ADDR);
    user_rready  = (r_state == S_RD_DATA);
    user_awburst = user_awvalid ? 2'b01 : 2'b00;
    user_arburst = user_arvalid ? 2'b01 : 2'b00;
    user_wstrb   = user_wvalid ? '1 : '0;
    user_wlast   = user_wvalid & w_last_beat;
  end

  assign user_awid   = r_id;
  assign user_awaddr = r_addr;
  assign user_awlen  = r_len;
  assign user_awsize = LP_SIZE;
  assign user_arid   = r_id;
  assign user_araddr = r_addr;
  assign user_arlen  = r_len;
  assign user_arsize = LP_SIZE;
  assign user_wid    = r_id;
  assign user_wdata  = w_pattern;
  assign err_cnt     = r_err_cnt;

  // Command latch, beat counter and error accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_len     <= '0;
      r_id      <= '0;
      r_seed    <= '0;
      r_k       <= '0;
      r_err     <= 1'b0;
      r_past    <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_cmd_hs) begin
        r_addr <= cmd_addr;
        r_len  <= cmd_len;
        r_id   <= cmd_id;
        r_seed <= cmd_seed;
        r_k    <= '0;
        r_err  <= 1'b0;
        r_past <= 1'b0;
      end
      if (w_w_hs || w_r_hs) r_k <= r_k + 8'd1;
      if (w_b_hs && ((user_bresp != 2'b00) || (user_bid != r_id))) r_err <= 1'b1;
      if (w_r_hs && w_rd_beat_err) r_err <= 1'b1;
      if (w_r_hs && w_last_beat && !user_rlast) r_past <= 1'b1;
      if ((r_state == S_DONE) && r_err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

endmodule
